// File: rtl/ysyx_24100006_mdu.sv
// Iterative RV32M multiply/divide unit. Shift-add multiply and restoring
// divide, both one bit per cycle, with valid/ready handshakes on both sides.
module ysyx_24100006_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      mdu_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zf,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   hi;      // product high half / partial remainder
    logic [XLEN-1:0]   lo;      // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0]   opb;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_val;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    // Operand signedness, magnitudes and the RISC-V division corner cases
    always_comb begin
        a_sgn    = mdu_op[2] ? !mdu_op[0] : (mdu_op == 3'b001 || mdu_op == 3'b010);
        b_sgn    = mdu_op[2] ? !mdu_op[0] : (mdu_op == 3'b001);
        a_neg    = a_sgn & rs1_data[XLEN-1];
        b_neg    = b_sgn & rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        // REM takes the dividend sign; everything else the product of signs
        neg_in   = (mdu_op[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
        div_zero = mdu_op[2] & (rs2_data == '0);
        div_ovf  = mdu_op[2] & !mdu_op[0] & (rs1_data == XMIN) & (rs2_data == '1);
        special  = div_zero | div_ovf;
        if (div_zero)
            spec_val = mdu_op[1] ? rs1_data : '1;
        else
            spec_val = mdu_op[1] ? '0 : rs1_data;
    end

    // One iteration step of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        rem_shift = {hi, lo[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, opb};
    end

    // Sign fix-up and result selection on the magnitude result
    always_comb begin
        prod     = {hi, lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lo : lo;
        rem_fix  = neg_q ? -hi : hi;
        case (op_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    assign accept = (state == IDLE) & in_valid & !flush;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (!flush && in_valid) state_nx = special ? DONE : CALC;
            CALC: if (flush)              state_nx = IDLE;
                  else if (cnt == '0)     state_nx = FIX;
            FIX:  state_nx = flush ? IDLE : DONE;
            DONE: if (flush || out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and status outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath: operand capture, iteration and result register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt   <= CNT_W'(XLEN - 1);
            op_q  <= mdu_op;
            neg_q <= neg_in;
            hi    <= '0;
            // multiply: lo = multiplier, opb = multiplicand
            // divide:   lo = dividend,   opb = divisor
            lo    <= mdu_op[2] ? a_mag : b_mag;
            opb   <= mdu_op[2] ? b_mag : a_mag;
            if (special) result_q <= spec_val;
        end else if (state == CALC) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (!op_q[2]) begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end else if (!rem_diff[XLEN]) begin
                hi <= rem_diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
                hi <= rem_shift[XLEN-1:0];
                lo <= {lo[XLEN-2:0], 1'b0};
            end
        end else if (state == FIX && !flush) begin
            result_q <= fix_val;
        end
    end

    assign result = result_q;
    assign zf     = (result_q == '0);

endmodule

// File: tb/tb_ysyx_24100006_mdu.sv
// Directed table-driven bench for the iterative multiply/divide unit.
module tb_ysyx_24100006_mdu;

    localparam int XLEN = 32;
    localparam int NV   = 34;

    logic            clock, reset, flush, in_valid, in_ready, out_valid, out_ready, zf, busy;
    logic [2:0]      mdu_op;
    logic [XLEN-1:0] rs1_data, rs2_data, result;

    int tests  = 0;
    int failed = 0;

    ysyx_24100006_mdu #(.XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .mdu_op(mdu_op),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zf(zf), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          spec;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issue one op from IDLE, wait (bounded) for out_valid, then complete the handshake
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat);
        mdu_op = op; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        res = result;
        z   = zf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          seen;

        vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'h00000007, 32'h00000002, 32'h00000003, 1'b0};
        vecs[7]  = '{3'b111, 32'h00000007, 32'h00000002, 32'h00000001, 1'b0};
        vecs[8]  = '{3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{3'b110, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1};
        vecs[10] = '{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1};
        vecs[12] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[13] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[14] = '{3'b000, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF1, 1'b0};
        vecs[15] = '{3'b001, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0};
        vecs[16] = '{3'b010, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0};
        vecs[17] = '{3'b010, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[18] = '{3'b011, 32'h80000000, 32'h00000004, 32'h00000002, 1'b0};
        vecs[19] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0};
        vecs[20] = '{3'b101, 32'd100,      32'd7,        32'd14,       1'b0};
        vecs[21] = '{3'b111, 32'd100,      32'd7,        32'd2,        1'b0};
        vecs[22] = '{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
        vecs[23] = '{3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        1'b0};
        vecs[24] = '{3'b100, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0};
        vecs[25] = '{3'b110, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0};
        vecs[26] = '{3'b101, 32'd3,        32'd5,        32'd0,        1'b0};
        vecs[27] = '{3'b111, 32'd3,        32'd5,        32'd3,        1'b0};
        vecs[28] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0};
        vecs[29] = '{3'b000, 32'd0,        32'd12345,    32'd0,        1'b0};
        vecs[30] = '{3'b100, 32'h80000000, 32'd2,        32'hC0000000, 1'b0};
        vecs[31] = '{3'b011, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0};
        vecs[32] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        vecs[33] = '{3'b110, 32'h80000000, 32'd3,        32'hFFFFFFFE, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mdu_op = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) tick();
        check("rst_result", 64'(result), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_zf", 64'(zf), 64'h1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("vec%0d_zf", i), 64'(z), 64'(vecs[i].exp == 32'h0));
            check($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].spec ? 64'd1 : 64'(XLEN + 2));
            check($sformatf("vec%0d_in_ready_after", i), 64'(in_ready), 64'h1);
        end

        // Back-pressure; in_valid stays high while busy and must be ignored
        mdu_op = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; in_valid = 1'b1;
        tick();
        rs1_data = 32'hDEAD; mdu_op = 3'b000;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("bp_out_valid_seen", 64'(out_valid), 64'h1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d_result", k), 64'(result), 64'd14);
            check($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'h0);
            check($sformatf("bp_hold%0d_out_valid", k), 64'(out_valid), 64'h1);
            tick();
        end
        mdu_op = 3'b011; rs1_data = 32'h80000000; rs2_data = 32'd4;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_out_valid", 64'(out_valid), 64'h0);
        check("bp_release_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("b2b_accepted_busy", 64'(busy), 64'h1);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("b2b_latency", 64'(lat), 64'(XLEN + 2));
        check("b2b_result", 64'(result), 64'h2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush at CALC cycle 10
        mdu_op = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("flush_calc_busy_before", 64'(busy), 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_calc_in_ready", 64'(in_ready), 64'h1);
        check("flush_calc_busy", 64'(busy), 64'h0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("flush_calc_no_out_valid", 64'(seen), 64'h0);

        // Flush in IDLE blocks an accept
        mdu_op = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'h0);

        // Flush in DONE drops the result
        mdu_op = 3'b100; rs1_data = 32'd9; rs2_data = 32'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("flush_done_out_valid", 64'(out_valid), 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_done_dropped", 64'(out_valid), 64'h0);
        check("flush_done_in_ready", 64'(in_ready), 64'h1);

        // Reset mid-CALC
        mdu_op = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_result", 64'(result), 64'h0);
        check("rst_mid_out_valid", 64'(out_valid), 64'h0);
        check("rst_mid_busy", 64'(busy), 64'h0);
        check("rst_mid_in_ready", 64'(in_ready), 64'h1);
        check("rst_mid_zf", 64'(zf), 64'h1);
        reset = 1'b0;
        tick();

        run_op(3'b000, 32'd3, 32'd5, res, z, lat);
        check("post_rst_result", 64'(res), 64'd15);
        check("post_rst_latency", 64'(lat), 64'(XLEN + 2));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_mdu.md
Name: ysyx_24100006_mdu

Overview:
- Iterative multiply/divide unit for the RV32M extension. It sits beside the single-cycle ALU in the EX stage.
- It takes rs1/rs2 operands and a funct3-encoded op under a valid/ready handshake, and computes one bit per cycle.
- It holds the result until the consumer accepts it.
- It is generalised over operand width and adds multi-cycle sequencing, RISC-V corner-case handling, flush and back-pressure.

Parameters:
- XLEN, 32, operand and result width. Must be ≥ 4 and a power of 2.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clock  in  1  system clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  abandons the in-flight operation (pipeline redirect).
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept an operation.
- mdu_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  XLEN  first operand (dividend / multiplicand).
- rs2_data  in  XLEN  second operand (divisor / multiplier).
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  final result.
- zf  out  1  result == 0. Valid when out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- **Reset:** clock and reset only, synchronous active-high.
  - State goes to IDLE; counter = 0.
  - result = 0, out_valid = 0, busy = 0, in_ready = 1, zf = 1.
  - Reset mid-operation discards all work.
- **State machine:** IDLE, CALC, FIX, DONE.
- **in_ready** = (state == IDLE). Accept occurs on in_valid & in_ready at edge T; the op and operand signs are latched.
- **Operand preparation at accept:**
  - Signed operands (MULH, DIV, REM, and rs1 only for MULHSU) are converted to magnitudes.
  - neg_res is latched:
    - MUL*: sign(rs1) ^ sign(rs2), using the signedness rules above.
    - DIV: sign(rs1) ^ sign(rs2).
    - REM: sign(rs1).
  - The MUL low word is sign-independent.
- **Division special cases**, decided at accept; the state goes directly to DONE and out_valid is asserted at T+1:
  - Divisor == 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - DIV/REM with rs1 = 0x80..0 and rs2 = all ones: DIV → 0x80..0; REM → 0.
- **CALC:** runs exactly XLEN cycles (T+1 .. T+XLEN); the counter decrements from XLEN-1 to 0.
  - Multiply: shift-add on a 2·XLEN accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring algorithm, one quotient bit per cycle, MSB first. XLEN+1-bit partial remainder; the subtraction is kept if its result is non-negative.
- **FIX:** one cycle (T+XLEN+1). It negates the magnitude result (two's complement) if neg_res, then selects:
  - MUL → low XLEN bits.
  - MULH / MULHSU / MULHU → high XLEN bits.
  - DIV(U) → quotient.
  - REM(U) → remainder.
- **DONE:** out_valid = 1 starting T+XLEN+2 (normal) or T+1 (special case).
  - result and zf stay stable while out_valid & !out_ready.
  - On out_ready the state goes to IDLE and out_valid drops next cycle.
  - No new accept occurs in the same cycle as the result handshake; in_ready rises the cycle after.
- **flush:**
  - In CALC or FIX: next state IDLE, out_valid stays 0, and no result is produced.
  - In DONE: the result is dropped and the state goes to IDLE.
  - In IDLE: flush blocks an accept that cycle, and flush has priority over in_valid.
  - Reset has priority over flush.
- **Input stability:** inputs are ignored outside IDLE, so in_valid held high while busy has no effect.
- **Widths:** all internal arithmetic is unsigned on magnitudes; no width truncation occurs before FIX.

Test Plan:
- MUL 0xFFFFFFFF × 0xFFFFFFFF (XLEN=32) → MUL = 0x00000001, MULH = 0x00000000, MULHU = 0xFFFFFFFE, MULHSU = 0xFFFFFFFF. out_valid exactly 34 cycles after accept.
- DIV −7 / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 7 / 2 → 3. REMU → 1. zf = 0 in all cases.
- Divide by zero: DIV 5 / 0 → 0xFFFFFFFF and REM → 5, both one cycle after accept. Overflow: DIV 0x80000000 / −1 → 0x80000000 and REM → 0 with zf = 1.
- Back-pressure: out_ready held low 5 cycles after out_valid → result stable and in_ready = 0 throughout. Release → in_ready = 1 the next cycle, and a back-to-back op is accepted.
- Flush at CALC cycle 10 → out_valid never asserts and in_ready = 1 the next cycle. Reset asserted mid-CALC → all outputs at reset values the next cycle.
- Randomised regression of 10k ops against a reference model, including 0, 1, −1, MIN and MAX operands, at XLEN=32 and XLEN=64.
